// File: rtl/ifu_pkg.sv
// Shared types for the miniRV instruction fetch unit: FSM states and FIFO entry payload.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    KILL
  } ifu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer between fetch and decode. The head entry and the valid flag
// are registered, so decode sees stable outputs and the head holds its value when empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;
  logic          valid_q, valid_d;
  logic          pop;
  logic          push;

  // Pop is applied before push, so a full buffer can accept a push in the same cycle.
  always_comb begin
    pop      = pop_i && (count_q != '0);
    push     = push_i && !flush_i;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data_i;
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    valid_d = (count_d != '0);
    head_d  = head_q;
    if (valid_d) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = !valid_q;
  assign head_o  = head_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && full_o && !pop_i));

endmodule

// File: rtl/ifu.sv
// miniRV instruction fetch unit: owns the PC, issues one word fetch at a time under a
// buffer credit rule, and handles redirects. Optional counters under IFU_PERF_EN.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned  FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_valid_q, req_valid_d;
  logic          hs;
  logic          push;
  logic          pop;
  logic          wait_credit;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign hs   = (state_q == REQ) && imem_req_ready;
  assign pop  = !fifo_empty && inst_ready;
  assign push = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  // Credit left once this response lands and any concurrent pop has drained.
  assign wait_credit = (fifo_count + CW'(1) - CW'(pop)) < CW'(FIFO_DEPTH);
  // pc already advanced past the outstanding request while in WAIT.
  assign push_entry = '{inst: imem_rsp_data, pc: pc_q - 32'd4};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE:    if (!fifo_full) state_d = REQ;
      REQ:     if (hs) begin
                 pc_d    = pc_q + 32'd4;
                 state_d = WAIT;
               end
      WAIT:    if (imem_rsp_valid) state_d = wait_credit ? REQ : IDLE;
      KILL:    if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // A response arriving with the redirect settles the owed reply, so no KILL is needed.
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = hs ? KILL : REQ;
        WAIT:    state_d = imem_rsp_valid ? REQ : KILL;
        KILL:    state_d = imem_rsp_valid ? REQ : KILL;
        default: state_d = IDLE;
      endcase
    end
    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = !fifo_empty;
  assign inst           = head.inst;
  assign inst_pc        = head.pc;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;
  logic        kill;

  assign kill = imem_rsp_valid && ((state_q == KILL) || ((state_q == WAIT) && redirect_valid));

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(hs);
    kill_cnt_d  = kill_cnt_q + 32'(kill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a one-cycle-latency memory model with a response hold input,
// a decoder capture queue, and one task per scenario.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic        rsp_hold;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] acc_addr[$];

  ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_kill_cnt (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] got_pc_at(input int i);
    if (i < got_pc.size()) return got_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_inst_at(input int i);
    if (i < got_inst.size()) return got_inst[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_addr.size()) return acc_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Memory: answers each accepted request in the following cycle unless held.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend           = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend && !rsp_hold) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(pend_addr);
        pend           = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        acc_addr.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_inst.push_back(inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic dec_rdy, input logic hold);
    rst_n          = 1'b0;
    imem_req_ready = rdy;
    inst_ready     = dec_rdy;
    rsp_hold       = hold;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    got_pc.delete();
    got_inst.delete();
    acc_addr.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input string name);
    int budget = 80;
    while (got_pc.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (got_pc.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d instructions, required %0d", name, got_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    rsp_hold       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_req_addr: got %h required 80000000", imem_req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b required 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h required 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h required 0", inst_pc); end
`ifdef IFU_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_fetch: got %0d required 0", perf_fetch_cnt); end
    checks++; if (perf_kill_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf_kill: got %0d required 0", perf_kill_cnt); end
`endif
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1, 1'b0);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_req_valid: got %b required 0", imem_req_valid); end
    tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stream_c1_req_valid: got %b required 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stream_c1_addr: got %h required 80000000", imem_req_addr); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_c2_inst_valid: got %b required 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_c3_inst_valid: got %b required 1", inst_valid); end
    checks++; if (inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL stream_c3_inst_pc: got %h required 80000000", inst_pc); end
    checks++; if (inst !== 32'h9357_9BDF) begin errors++; $display("FAIL stream_c3_inst: got %h required 93579bdf", inst); end
    wait_got(3, "stream");
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h8000_0000 + 32'(4 * i);
      checks++; if (got_pc_at(i) !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h required %h", i, got_pc_at(i), exp_pc); end
      checks++; if (got_inst_at(i) !== mem_fn(exp_pc)) begin errors++; $display("FAIL stream_inst[%0d]: got %h required %h", i, got_inst_at(i), mem_fn(exp_pc)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b required 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b required 1", inst_valid); end
    checks++; if (inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_inst_pc: got %h required 80000000", inst_pc); end
    checks++; if (acc_addr.size() !== 2) begin errors++; $display("FAIL bp_accepted: got %0d required 2", acc_addr.size()); end
    inst_ready = 1'b1;
    wait_got(4, "bp");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'h8000_0000 + 32'(4 * i);
      checks++; if (got_pc_at(i) !== exp_pc) begin errors++; $display("FAIL bp_pc[%0d]: got %h required %h", i, got_pc_at(i), exp_pc); end
      checks++; if (got_inst_at(i) !== mem_fn(exp_pc)) begin errors++; $display("FAIL bp_inst[%0d]: got %h required %h", i, got_inst_at(i), mem_fn(exp_pc)); end
    end
  endtask

  task automatic test_req_stall();
    do_reset(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid[c%0d]: got %b required 1", i, imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stall_addr[c%0d]: got %h required 80000000", i, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_after_req_valid: got %b required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL stall_after_pc: got %h required 80000004", imem_req_addr); end
    checks++; if (acc_addr.size() !== 1) begin errors++; $display("FAIL stall_accepted: got %0d required 1", acc_addr.size()); end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rsp_hold = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rdw_pre_inst_valid: got %b required 1", inst_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_pre_req_valid: got %b required 0", imem_req_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    inst_ready     = 1'b1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_flush_inst_valid: got %b required 0", inst_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_kill_req_valid: got %b required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rdw_new_pc: got %h required 80000100", imem_req_addr); end
    wait_got(2, "rdw");
    checks++; if (got_pc_at(0) !== 32'h8000_0100) begin errors++; $display("FAIL rdw_pc0: got %h required 80000100", got_pc_at(0)); end
    checks++; if (got_inst_at(0) !== mem_fn(32'h8000_0100)) begin errors++; $display("FAIL rdw_inst0: got %h required %h", got_inst_at(0), mem_fn(32'h8000_0100)); end
    checks++; if (got_pc_at(1) !== 32'h8000_0104) begin errors++; $display("FAIL rdw_pc1: got %h required 80000104", got_pc_at(1)); end
`ifdef IFU_PERF_EN
    checks++; if (perf_kill_cnt !== 32'd1) begin errors++; $display("FAIL rdw_perf_kill: got %0d required 1", perf_kill_cnt); end
`endif
  endtask

  task automatic test_redirect_kill();
    do_reset(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h9000_0000;
    tick();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdk_req_valid: got %b required 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h9000_0000) begin errors++; $display("FAIL rdk_addr: got %h required 90000000", imem_req_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hA000_0000;
    tick();
    redirect_pc    = 32'hB000_000B;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdk_kill1_req_valid: got %b required 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdk_kill2_req_valid: got %b required 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'hB000_0008) begin errors++; $display("FAIL rdk_kill2_pc: got %h required b0000008", imem_req_addr); end
    tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdk_final_req_valid: got %b required 1", imem_req_valid); end
    wait_got(1, "rdk");
    checks++; if (got_pc_at(0) !== 32'hB000_0008) begin errors++; $display("FAIL rdk_pc0: got %h required b0000008", got_pc_at(0)); end
    checks++; if (got_inst_at(0) !== mem_fn(32'hB000_0008)) begin errors++; $display("FAIL rdk_inst0: got %h required %h", got_inst_at(0), mem_fn(32'hB000_0008)); end
    checks++; if (acc_at(1) !== 32'h9000_0000) begin errors++; $display("FAIL rdk_acc1: got %h required 90000000", acc_at(1)); end
    checks++; if (acc_at(2) !== 32'hB000_0008) begin errors++; $display("FAIL rdk_acc2: got %h required b0000008", acc_at(2)); end
`ifdef IFU_PERF_EN
    checks++; if (perf_kill_cnt !== 32'd2) begin errors++; $display("FAIL rdk_perf_kill: got %0d required 2", perf_kill_cnt); end
`endif
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    repeat (4) tick();
    imem_req_ready = 1'b0;
    repeat (3) tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_req_valid: got %b required 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0000_0004) begin errors++; $display("FAIL wrap_addr: got %h required 00000004", imem_req_addr); end
    checks++; if (got_pc.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d required 2", got_pc.size()); end
    checks++; if (got_pc_at(0) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h required fffffffc", got_pc_at(0)); end
    checks++; if (got_pc_at(1) !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc1: got %h required 00000000", got_pc_at(1)); end
    checks++; if (got_inst_at(1) !== mem_fn(32'h0)) begin errors++; $display("FAIL wrap_inst1: got %h required %h", got_inst_at(1), mem_fn(32'h0)); end
`ifdef IFU_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL wrap_perf_fetch: got %0d required 3", perf_fetch_cnt); end
    checks++; if (perf_kill_cnt !== 32'd1) begin errors++; $display("FAIL wrap_perf_kill: got %0d required 1", perf_kill_cnt); end
`endif
  endtask

  initial begin
    pend      = 1'b0;
    pend_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_wait();
    test_redirect_kill();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
